pwm_channel_ctrl: RTL
=====================

// Module: pwm_channel_ctrl
// PURPOSE
// - Control stage for one PWM channel; sits beside the period counter (flex_counter).
// - Drives the counter's clear, count_enable and rollover_val inputs.
// - Consumes the counter's count_out and rollover_flag to produce a registered PWM waveform.
// - Double-buffers period/duty/polarity so updates take effect only on a period boundary (glitch-free).
// PARAMETERS
// - NUM_CNT_BITS    32  width of period, duty and counter value
// PORTS
// - clk              in   1   system clock; all logic on rising edge
// - rst              in   1   asynchronous, active-high reset
// - cfg_enable       in   1   level; 1 = run channel, 0 = stop at end of current period
// - cfg_oneshot      in   1   1 = run exactly one period, then stop
// - cfg_period       in   N   requested period in clk cycles (0 = invalid)
// - cfg_duty         in   N   requested active cycles per period
// - cfg_polarity     in   1   0 = active-high output, 1 = active-low output
// - cfg_update       in   1   1-cycle pulse: capture cfg_period/duty/polarity into staging
// - cnt_value        in   N   counter count_out
// - cnt_rollover     in   1   counter rollover_flag (high while cnt_value == period)
// - cnt_clear        out  1   counter clear
// - cnt_enable       out  1   counter count_enable
// - cnt_rollover_val out  N   active period to counter
// - pwm_out          out  1   PWM waveform, registered
// - period_done      out  1   1-cycle pulse, registered, when a period completes
// - busy             out  1   high in START/RUN/STOP
// - update_pending   out  1   staged values not yet applied
// BEHAVIOUR
// - Reset values:
//   - Outputs: cnt_clear=1, cnt_enable=0, cnt_rollover_val=0, pwm_out=0, period_done=0, busy=0, update_pending=0.
//   - Internal: state=IDLE; active and staging registers = 0.
// - Counter contract: after clear the count is 0; while enabled it counts 1..P, then wraps to 1.
//   - Period = P cycles.
//   - cnt_rollover is high in the cycle cnt_value == P.
// - FSM IDLE (cnt_clear=1, cnt_enable=0):
//   - If cfg_enable=1 and cfg_period!=0: load active_period/duty/pol from live cfg_*; clear update_pending; go to START.
//   - If cfg_period==0: stay in IDLE.
// - FSM START (cnt_clear=0, cnt_enable=1): go to RUN next cycle; counter reads 1 in the first RUN cycle.
// - FSM RUN (cnt_clear=0, cnt_enable=1), on cnt_rollover:
//   - Pulse period_done next cycle.
//   - If update_pending: copy staging into active and clear update_pending.
//     - The new period applies from the next count==1.
//     - A staged period of 0 is discarded: active values kept, update_pending cleared.
//   - Then go to STOP if cfg_oneshot=1 or cfg_enable=0; otherwise stay in RUN.
// - FSM STOP (cnt_clear=1, cnt_enable=0): go to IDLE next cycle.
// - cnt_rollover_val = active_period (registered; changes only at IDLE start or on a RUN boundary).
// - Dropping cfg_enable mid-period does not truncate the period; the period is finished first.
// - pwm_out (registered, 1-cycle latency from cnt_value):
//   - pwm_out <= active_pol ^ (state==RUN && cnt_value>=1 && cnt_value<=active_duty).
//   - duty=0 gives a constant inactive level; duty>=period gives a constant active level.
//   - Outside RUN, pwm_out = active_pol (inactive level).
// - cfg_update in any state: staging <= live cfg_*; update_pending <= 1. A later pulse overwrites staging.
// - cfg_update coinciding with cnt_rollover: the old staging is applied at the boundary.
//   - The new capture lands in staging and update_pending stays 1 for the next boundary.
// - Comparisons are unsigned, N bits; no arithmetic overflow paths.
// - rst asserted mid-operation: everything returns to reset values at once; the counter is cleared via cnt_clear=1.
// TESTING
// - Basic waveform: period=5, duty=2, pol=0, enable=1 -> pwm_out pattern 1,1,0,0,0 repeating (1-cycle lag); period_done every 5 cycles.
// - Glitch-free update: running period=4, duty=1; cfg_update with period=8, duty=6 mid-period -> current period finishes as 4/1, next is 8/6; update_pending 1 -> 0 at the boundary.
// - Extremes: duty=0 -> pwm_out constant 0; duty=9 with period=4 -> constant 1; pol=1 inverts both.
// - Stop/oneshot: oneshot=1, period=3 -> exactly one period_done, then busy=0, cnt_clear=1. With oneshot=0, drop enable at count=1 of period 6 -> stops after count 6.
// - Invalid config: enable with period=0 -> stays IDLE, busy=0. Staged period=0 while running -> ignored, old period continues.
// - Reset mid-run: assert rst at count=3 -> same cycle pwm_out=0, cnt_clear=1, busy=0; after release and enable, a fresh period starts from count 1.

Source files
------------

// File: rtl/pwm_channel_ctrl.sv
// pwm_channel_ctrl: control stage for one PWM channel next to a flex_counter.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   cfg_enable          - level: run channel (0 stops at end of current period)
//   cfg_oneshot         - run a single period, then stop
//   cfg_period/duty/pol - requested waveform (period 0 is invalid)
//   cfg_update          - pulse: capture cfg_* into staging
//   cnt_value           - counter count_out
//   cnt_rollover        - counter rollover_flag
//   cnt_clear/enable    - counter control (registered)
//   cnt_rollover_val    - active period to counter (registered)
//   pwm_out             - PWM waveform (registered, 1-cycle lag from cnt_value)
//   period_done         - 1-cycle pulse after each completed period
//   busy                - high in START/RUN/STOP
//   update_pending      - staged values waiting for a period boundary
module pwm_channel_ctrl #(
    parameter int unsigned NUM_CNT_BITS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_enable,
    input  logic                    cfg_oneshot,
    input  logic [NUM_CNT_BITS-1:0] cfg_period,
    input  logic [NUM_CNT_BITS-1:0] cfg_duty,
    input  logic                    cfg_polarity,
    input  logic                    cfg_update,
    input  logic [NUM_CNT_BITS-1:0] cnt_value,
    input  logic                    cnt_rollover,
    output logic                    cnt_clear,
    output logic                    cnt_enable,
    output logic [NUM_CNT_BITS-1:0] cnt_rollover_val,
    output logic                    pwm_out,
    output logic                    period_done,
    output logic                    busy,
    output logic                    update_pending
);

    localparam int unsigned W = NUM_CNT_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   active_period_q, active_period_d;
    logic [W-1:0]   active_duty_q, active_duty_d;
    logic           active_pol_q, active_pol_d;
    logic [W-1:0]   stage_period_q, stage_period_d;
    logic [W-1:0]   stage_duty_q, stage_duty_d;
    logic           stage_pol_q, stage_pol_d;
    logic           update_pending_q, update_pending_d;
    logic           cnt_clear_q, cnt_clear_d;
    logic           cnt_enable_q, cnt_enable_d;
    logic           pwm_q, pwm_d;
    logic           period_done_q, period_done_d;
    logic           busy_q, busy_d;

    // State and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            active_period_q  <= '0;
            active_duty_q    <= '0;
            active_pol_q     <= 1'b0;
            stage_period_q   <= '0;
            stage_duty_q     <= '0;
            stage_pol_q      <= 1'b0;
            update_pending_q <= 1'b0;
            cnt_clear_q      <= 1'b1;
            cnt_enable_q     <= 1'b0;
            pwm_q            <= 1'b0;
            period_done_q    <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            active_period_q  <= active_period_d;
            active_duty_q    <= active_duty_d;
            active_pol_q     <= active_pol_d;
            stage_period_q   <= stage_period_d;
            stage_duty_q     <= stage_duty_d;
            stage_pol_q      <= stage_pol_d;
            update_pending_q <= update_pending_d;
            cnt_clear_q      <= cnt_clear_d;
            cnt_enable_q     <= cnt_enable_d;
            pwm_q            <= pwm_d;
            period_done_q    <= period_done_d;
            busy_q           <= busy_d;
        end
    end

    // Next-state, buffer update and output decode.
    always_comb begin
        state_d          = state_q;
        active_period_d  = active_period_q;
        active_duty_d    = active_duty_q;
        active_pol_d     = active_pol_q;
        stage_period_d   = stage_period_q;
        stage_duty_d     = stage_duty_q;
        stage_pol_d      = stage_pol_q;
        update_pending_d = update_pending_q;
        period_done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_enable && (cfg_period != '0)) begin
                    active_period_d  = cfg_period;
                    active_duty_d    = cfg_duty;
                    active_pol_d     = cfg_polarity;
                    update_pending_d = 1'b0;
                    state_d          = S_START;
                end
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_rollover) begin
                    period_done_d = 1'b1;
                    if (update_pending_q) begin
                        // A staged period of 0 is dropped; the running config stays.
                        if (stage_period_q != '0) begin
                            active_period_d = stage_period_q;
                            active_duty_d   = stage_duty_q;
                            active_pol_d    = stage_pol_q;
                        end
                        update_pending_d = 1'b0;
                    end
                    if (cfg_oneshot || !cfg_enable) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A capture coinciding with a boundary wins the pending flag for the next one.
        if (cfg_update) begin
            stage_period_d   = cfg_period;
            stage_duty_d     = cfg_duty;
            stage_pol_d      = cfg_polarity;
            update_pending_d = 1'b1;
        end

        // Counter controls are registered from the next state so they track the FSM.
        cnt_clear_d  = (state_d == S_IDLE) || (state_d == S_STOP);
        cnt_enable_d = (state_d == S_START) || (state_d == S_RUN);
        busy_d       = (state_d != S_IDLE);

        pwm_d = active_pol_q ^ ((state_q == S_RUN) && (cnt_value != '0)
                                && (cnt_value <= active_duty_q));
    end

    assign cnt_clear        = cnt_clear_q;
    assign cnt_enable       = cnt_enable_q;
    assign cnt_rollover_val = active_period_q;
    assign pwm_out          = pwm_q;
    assign period_done      = period_done_q;
    assign busy             = busy_q;
    assign update_pending   = update_pending_q;

endmodule
